// File: rtl/conway_pkg.sv
// State encodings, output decode and default widths shared by the Conway grid
// sequencer and its period timer.
package conway_pkg;

  localparam int DEF_DATA_SIZE = 5;
  localparam int DEF_PERIOD_W  = 8;
  localparam int DEF_GEN_W     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PAUSED = 3'd2,
    RUN    = 3'd3,
    COMMIT = 3'd4,
    STABLE = 3'd5
  } ctrl_state_t;

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_LOAD   = 3'(LOAD);
  localparam logic [2:0] ST_PAUSED = 3'(PAUSED);
  localparam logic [2:0] ST_RUN    = 3'(RUN);
  localparam logic [2:0] ST_COMMIT = 3'(COMMIT);
  localparam logic [2:0] ST_STABLE = 3'(STABLE);

  typedef struct packed {
    logic write_enable;
    logic load_run;
    logic busy;
    logic stable;
  } ctrl_out_t;

  // Moore decode: the controller registers this value of its next state.
  function automatic ctrl_out_t decode_outputs(logic [2:0] st);
    ctrl_out_t o;
    o.write_enable = (st == ST_LOAD) || (st == ST_COMMIT);
    o.load_run     = (st != ST_IDLE) && (st != ST_LOAD);
    o.busy         = (st == ST_LOAD) || (st == ST_RUN) || (st == ST_COMMIT);
    o.stable       = (st == ST_STABLE);
    return o;
  endfunction

endpackage

// File: rtl/life_step_controller_if.sv
// User-control / memory-control bundle of the Conway grid sequencer.
// master = user/datapath side, slave = the controller.
interface life_step_controller_if #(
  parameter int DATA_SIZE = 5,
  parameter int PERIOD_W  = 8,
  parameter int GEN_W     = 16
);
  logic                 load_req;
  logic                 run_req;
  logic                 step_req;
  logic [PERIOD_W-1:0]  period;
  logic [DATA_SIZE-1:0] grid_in;
  logic [DATA_SIZE-1:0] mem_out;
  logic                 write_enable;
  logic                 load_run;
  logic [GEN_W-1:0]     generation;
  logic                 busy;
  logic                 stable;

  modport master (
    output load_req, run_req, step_req, period, grid_in, mem_out,
    input  write_enable, load_run, generation, busy, stable
  );

  modport slave (
    input  load_req, run_req, step_req, period, grid_in, mem_out,
    output write_enable, load_run, generation, busy, stable
  );
endinterface

// File: rtl/life_period_timer.sv
// Free-run wait timer: counts 0..max(period,1)-1 while not cleared; tc flags
// the terminal count against the live period value.
module life_period_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tc
);
  logic [PERIOD_W-1:0] count_reg;
  logic [PERIOD_W-1:0] last_count;

  // Period 0 behaves as 1; ">=" lets a shortened period expire at once.
  always_comb last_count = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tc = (count_reg >= last_count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!tc) begin
      count_reg <= count_reg + PERIOD_W'(1);
    end
  end
endmodule

// File: rtl/life_step_controller.sv
// Conway grid memory sequencer: load, single-step / free-run, generation count.
// Optional fixed-point detection via LIFE_CTRL_STABLE_DETECT_EN.
module life_step_controller
  import conway_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int GEN_W     = DEF_GEN_W
) (
  input logic                   clk,
  input logic                   reset_n,
  life_step_controller_if.slave bus
);
  logic [2:0]       state_reg, state_next;
  logic [GEN_W-1:0] gen_reg, gen_next;
  ctrl_out_t        out_reg;
  logic             tc;
  logic             fixed_point;

`ifdef LIFE_CTRL_STABLE_DETECT_EN
  logic [DATA_SIZE-1:0] grid_diff;
  assign grid_diff   = bus.grid_in ^ bus.mem_out;
  assign fixed_point = (grid_diff == '0);
`else
  logic [DATA_SIZE-1:0] grid_unused;
  assign grid_unused = bus.grid_in ^ bus.mem_out;
  assign fixed_point = 1'b0;
`endif

  life_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg != ST_RUN),
    .period  (bus.period),
    .tc      (tc)
  );

  always_comb begin
    state_next = state_reg;
    gen_next   = gen_reg;
    case (state_reg)
      ST_IDLE: if (bus.load_req) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_PAUSED;
      ST_PAUSED: begin
        if (bus.load_req)      state_next = ST_LOAD;
        else if (bus.run_req)  state_next = ST_RUN;
        else if (bus.step_req) state_next = ST_COMMIT;
      end
      ST_RUN: begin
        if (bus.load_req)      state_next = ST_LOAD;
        else if (!bus.run_req) state_next = ST_PAUSED;
        else if (tc)           state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (fixed_point) begin
          state_next = ST_STABLE;
        end else begin
          gen_next   = gen_reg + GEN_W'(1);
          state_next = bus.run_req ? ST_RUN : ST_PAUSED;
        end
      end
      ST_STABLE: if (bus.load_req) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
    // Counter reads 0 for the whole load cycle, not just after it.
    if (state_next == ST_LOAD) gen_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      gen_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gen_reg   <= gen_next;
      out_reg   <= decode_outputs(state_next);
    end
  end

  assign bus.write_enable = out_reg.write_enable;
  assign bus.load_run     = out_reg.load_run;
  assign bus.busy         = out_reg.busy;
  assign bus.stable       = out_reg.stable;
  assign bus.generation   = gen_reg;
endmodule

// File: tb/tb_life_step_controller.sv
// Self-checking bench for life_step_controller: vector table, corner-case
// sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_life_step_controller;
  localparam int DW = 5;
  localparam int PW = 8;

`ifdef LIFE_CTRL_STABLE_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  life_step_controller_if #(.DATA_SIZE(DW), .PERIOD_W(PW), .GEN_W(16)) bus ();
  life_step_controller_if #(.DATA_SIZE(DW), .PERIOD_W(PW), .GEN_W(4))  bus4 ();

  life_step_controller #(.DATA_SIZE(DW), .PERIOD_W(PW), .GEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  life_step_controller #(.DATA_SIZE(DW), .PERIOD_W(PW), .GEN_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  // The narrow-counter instance sees identical stimulus.
  assign bus4.load_req = bus.load_req;
  assign bus4.run_req  = bus.run_req;
  assign bus4.step_req = bus.step_req;
  assign bus4.period   = bus.period;
  assign bus4.grid_in  = bus.grid_in;
  assign bus4.mem_out  = bus.mem_out;

  int checks = 0;
  int passes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_NONE, M_LOADING, M_HOLD, M_WAITING, M_WRITING, M_FIXED} mode_t;
  mode_t m_mode = M_NONE;
  int    m_elapsed = 0;
  int    m_gen = 0;

  task automatic model_reset();
    m_mode = M_NONE; m_elapsed = 0; m_gen = 0;
  endtask

  task automatic model_step();
    int wait_len;
    if (!reset_n) begin
      model_reset();
      return;
    end
    wait_len = (bus.period == 0) ? 1 : int'(bus.period);
    case (m_mode)
      M_NONE:    if (bus.load_req) begin m_mode = M_LOADING; m_gen = 0; end
      M_LOADING: m_mode = M_HOLD;
      M_HOLD: begin
        if (bus.load_req)      begin m_mode = M_LOADING; m_gen = 0; end
        else if (bus.run_req)  begin m_mode = M_WAITING; m_elapsed = 0; end
        else if (bus.step_req) m_mode = M_WRITING;
      end
      M_WAITING: begin
        if (bus.load_req)                  begin m_mode = M_LOADING; m_gen = 0; end
        else if (!bus.run_req)             m_mode = M_HOLD;
        else if (m_elapsed + 1 >= wait_len) m_mode = M_WRITING;
        else                               m_elapsed++;
      end
      M_WRITING: begin
        if (DETECT && (bus.grid_in == bus.mem_out)) m_mode = M_FIXED;
        else begin
          m_gen++;
          if (bus.run_req) begin m_mode = M_WAITING; m_elapsed = 0; end
          else m_mode = M_HOLD;
        end
      end
      M_FIXED: if (bus.load_req) begin m_mode = M_LOADING; m_gen = 0; end
      default: m_mode = M_NONE;
    endcase
  endtask

  // {write_enable, load_run, busy, stable}
  function automatic logic [3:0] model_flags();
    logic we, lr, bz, st;
    we = (m_mode == M_LOADING) || (m_mode == M_WRITING);
    lr = (m_mode != M_NONE) && (m_mode != M_LOADING);
    bz = (m_mode == M_LOADING) || (m_mode == M_WAITING) || (m_mode == M_WRITING);
    st = (m_mode == M_FIXED);
    return {we, lr, bz, st};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.write_enable, bus.load_run, bus.busy, bus.stable};
  endfunction

  function automatic logic [3:0] dut4_flags();
    return {bus4.write_enable, bus4.load_run, bus4.busy, bus4.stable};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(logic l, logic r, logic s, logic [PW-1:0] p);
    bus.load_req = l; bus.run_req = r; bus.step_req = s; bus.period = p;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic l, r, s;
    logic [PW-1:0] p;
    logic we, lr, bz;
    logic [15:0] gen;
  } vec_t;

  function automatic vec_t mk(logic l, logic r, logic s, logic [PW-1:0] p,
                              logic we, logic lr, logic bz, logic [15:0] gen);
    vec_t v;
    v.l = l; v.r = r; v.s = s; v.p = p; v.we = we; v.lr = lr; v.bz = bz; v.gen = gen;
    return v;
  endfunction

  vec_t vt[17];

  task automatic measure_gap(string name, int expect_gap);
    int last = -1, gap = -1, seen = 0;
    for (int c = 0; c < 40 && seen < 3; c++) begin
      tick();
      if (bus.write_enable) begin
        if (last >= 0) gap = c - last;
        last = c;
        seen++;
      end
    end
    check(name, gap, expect_gap);
  endtask

  initial begin
    int pulses;
    logic [15:0] gen_before;
    set_in(0, 0, 0, 0);
    bus.grid_in = 5'b00000;
    bus.mem_out = 5'b11111;
    model_reset();

    #1;
    check("reset_flags", {28'd0, dut_flags()}, 32'd0);
    check("reset_gen", bus.generation, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Load, single steps, dropped pulses, short free-run, pause.
    vt[0]  = mk(0,0,1,0, 0,0,0,0);
    vt[1]  = mk(0,1,0,0, 0,0,0,0);
    vt[2]  = mk(1,0,0,0, 1,0,1,0);
    vt[3]  = mk(0,0,0,0, 0,1,0,0);
    vt[4]  = mk(0,0,1,0, 1,1,1,0);
    vt[5]  = mk(0,0,0,0, 0,1,0,1);
    vt[6]  = mk(0,0,1,0, 1,1,1,1);
    vt[7]  = mk(0,0,1,0, 0,1,0,2);
    vt[8]  = mk(0,0,1,0, 1,1,1,2);
    vt[9]  = mk(0,0,0,0, 0,1,0,3);
    vt[10] = mk(1,0,1,0, 1,0,1,0);
    vt[11] = mk(1,0,0,0, 0,1,0,0);
    vt[12] = mk(0,1,0,2, 0,1,1,0);
    vt[13] = mk(0,1,0,2, 0,1,1,0);
    vt[14] = mk(0,1,0,2, 1,1,1,0);
    vt[15] = mk(0,1,0,2, 0,1,1,1);
    vt[16] = mk(0,0,0,2, 0,1,0,1);
    for (int i = 0; i < 17; i++) begin
      set_in(vt[i].l, vt[i].r, vt[i].s, vt[i].p);
      tick();
      check($sformatf("vec%0d_flags", i), {29'd0, dut_flags() >> 1},
            {29'd0, vt[i].we, vt[i].lr, vt[i].bz});
      check($sformatf("vec%0d_gen", i), bus.generation, vt[i].gen);
    end

    // Free-run spacing at period 4 and 0, then pause.
    set_in(0, 1, 0, 4);
    measure_gap("gap_period4", 5);
    bus.period = 0;
    measure_gap("gap_period0", 2);
    bus.run_req = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.write_enable) pulses++;
    end
    check("pause_no_pulses", pulses, 0);
    check("pause_flags", {28'd0, dut_flags()}, 32'h4);

    // Asynchronous reset in the middle of RUN.
    set_in(0, 1, 0, 6);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {11'd0, bus.generation, dut_flags(), dut4_flags()}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    set_in(0, 0, 1, 0); tick();
    check("idle_step", {28'd0, dut_flags()}, 32'd0);
    set_in(0, 1, 0, 0); tick();
    check("idle_run1", {28'd0, dut_flags()}, 32'd0);
    tick();
    check("idle_run2", {28'd0, dut_flags()}, 32'd0);

    // 4-bit generation wraps after 16 steps; load mid-RUN clears it.
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      bus.step_req = 1'b1; tick();
      bus.step_req = 1'b0; tick();
    end
    check("wrap_gen4", bus4.generation, 0);
    check("wrap_gen16", bus.generation, 16);
    set_in(0, 1, 0, 3);
    repeat (5) tick();
    bus.load_req = 1'b1; tick();
    check("midrun_load_flags", {28'd0, dut4_flags()}, 32'hA);
    check("midrun_load_gen", bus4.generation, 0);
    set_in(0, 0, 0, 0); tick();

`ifdef LIFE_CTRL_STABLE_DETECT_EN
    // Fixed point: no increment, run ignored, load clears stable.
    gen_before = bus.generation;
    bus.grid_in = 5'b00110;
    bus.mem_out = 5'b00110;
    bus.step_req = 1'b1; tick();
    bus.step_req = 1'b0; tick();
    check("stable_flags", {28'd0, dut_flags()}, 32'h5);
    check("stable_gen", bus.generation, gen_before);
    bus.run_req = 1'b1;
    repeat (4) tick();
    check("stable_run_ignored", {28'd0, dut_flags()}, 32'h5);
    set_in(1, 0, 0, 0); tick();
    check("stable_cleared", {28'd0, dut_flags()}, 32'hA);
    set_in(0, 0, 0, 0); tick();
    bus.grid_in = 5'b00000;
    bus.mem_out = 5'b11111;
`else
    gen_before = bus.generation;
    check("no_detect_stable", {31'd0, bus.stable}, 32'd0);
    check("no_detect_gen", bus.generation, gen_before);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.load_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) bus.run_req = ~bus.run_req;
      bus.step_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) bus.period = PW'($urandom_range(0, 5));
      bus.grid_in = DW'($urandom_range(0, 31));
      bus.mem_out = ($urandom_range(0, 7) == 0) ? bus.grid_in : DW'($urandom_range(0, 31));
      tick();
      check("rand_flags", {28'd0, dut_flags()}, {28'd0, model_flags()});
      check("rand_flags4", {28'd0, dut4_flags()}, {28'd0, model_flags()});
      check("rand_gen16", bus.generation, m_gen % 65536);
      check("rand_gen4", bus4.generation, m_gen % 16);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
